// File: rtl/noc_packet_sink.sv
// noc_packet_sink: receiving end of the credit-based mesh boundary link.
// Accepted flits are tagged with packet start/end by a small header/size/payload
// FSM and stored in a circular FIFO. The FIFO is read as a first-word-fall-through
// valid/ready stream. Delivered packets are counted, and an oversize length is
// recorded in a sticky flag.
//
// Handshakes:
//   input : a flit is taken on a rising edge iff rx_i && credit_o. The sender holds
//           data_i stable while credit_o is low.
//   output: a flit is consumed on a rising edge iff out_valid_o && out_ready_i.
//           out_data/sop/eop are stable while out_valid_o is high and unconsumed.
module noc_packet_sink #(
  parameter int FLIT_SIZE    = 32,
  parameter int BUFFER_DEPTH = 8,
  parameter int MAX_PAYLOAD  = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_i,
  output logic                 credit_o,
  input  logic [FLIT_SIZE-1:0] data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [FLIT_SIZE-1:0] out_data_o,
  output logic                 out_sop_o,
  output logic                 out_eop_o,
  output logic [15:0]          pkt_count_o,
  output logic                 len_err_o,
  output logic                 busy_o
);

  localparam int PTR_W   = $clog2(BUFFER_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = FLIT_SIZE + 2;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUFFER_DEPTH);
  // The length field is 16 bits wide, so the limit is compared in that width.
  localparam logic [15:0]      MAX_LEN = 16'(MAX_PAYLOAD);

  typedef enum logic [1:0] {
    S_HEADER  = 2'd0,
    S_SIZE    = 2'd1,
    S_PAYLOAD = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [15:0]              rem_q, rem_d;
  logic                     len_err_q, len_err_d;
  logic                     en_q, en_d;
  logic [ENTRY_W-1:0]       mem_q [BUFFER_DEPTH];
  logic [ENTRY_W-1:0]       mem_d [BUFFER_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [15:0]              pkt_count_q, pkt_count_d;

  logic                     push;
  logic                     pop;
  logic                     in_sop;
  logic                     in_eop;
  logic [15:0]              size_len;
  logic [ENTRY_W-1:0]       rd_entry;

  // Handshake qualifiers and the head-of-FIFO entry.
  always_comb begin
    credit_o    = en_q && (count_q < DEPTH_C);
    push        = rx_i && credit_o;
    out_valid_o = (count_q != '0);
    pop         = out_valid_o && out_ready_i;
    rd_entry    = mem_q[rd_ptr_q];
    out_data_o  = rd_entry[FLIT_SIZE-1:0];
    out_eop_o   = rd_entry[FLIT_SIZE];
    out_sop_o   = rd_entry[FLIT_SIZE+1];
    pkt_count_o = pkt_count_q;
    len_err_o   = len_err_q;
    busy_o      = (state_q != S_HEADER);
    size_len    = data_i[15:0];
  end

  // Packet delineation: tags each incoming flit and tracks the remaining payload.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    len_err_d = len_err_q;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    case (state_q)
      S_HEADER: begin
        in_sop = 1'b1;
        if (push) state_d = S_SIZE;
      end
      S_SIZE: begin
        in_eop = (size_len == 16'd0);
        if (push) begin
          rem_d = size_len;
          // Oversize packets are still forwarded in full; only the flag records them.
          if (size_len > MAX_LEN) len_err_d = 1'b1;
          state_d = (size_len == 16'd0) ? S_HEADER : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        in_eop = (rem_q == 16'd1);
        if (push) begin
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = S_HEADER;
        end
      end
      default: state_d = S_HEADER;
    endcase
  end

  // FIFO storage, pointers, occupancy and delivered-packet counter.
  always_comb begin
    en_d        = 1'b1;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pkt_count_d = pkt_count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {in_sop, in_eop, data_i};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (out_eop_o) pkt_count_d = pkt_count_q + 16'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // All state registers; reset clears storage so the outputs read as zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_HEADER;
      rem_q       <= '0;
      len_err_q   <= 1'b0;
      en_q        <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pkt_count_q <= '0;
      for (int i = 0; i < BUFFER_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      len_err_q   <= len_err_d;
      en_q        <= en_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pkt_count_q <= pkt_count_d;
      mem_q       <= mem_d;
    end
  end

endmodule

// File: tb/tb_noc_packet_sink.sv
// Bench for noc_packet_sink: directed packet scenarios plus a random-handshake run.
// A negedge process drives rx_i/out_ready_i and scores every delivered flit
// against the expected queue built from the packets the bench enqueued.
module tb_noc_packet_sink;

  localparam int W    = 34;   // {sop, eop, flit}
  localparam int NPKT = 150;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        rx_i;
  logic        credit_o;
  logic [31:0] data_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_data_o;
  logic        out_sop_o;
  logic        out_eop_o;
  logic [15:0] pkt_count_o;
  logic        len_err_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] tx_q[$];
  logic [W-1:0] exp_q[$];
  int rx_mode = 0;      // 0 idle, 1 send whenever possible, 2 random
  int ready_mode = 0;   // 0 stall, 1 always ready, 2 random
  bit pending = 1'b0;
  int acc_cnt = 0;
  int recv_cnt = 0;
  int exp_pkts = 0;
  bit exp_err = 1'b0;

  noc_packet_sink #(.FLIT_SIZE(32), .BUFFER_DEPTH(8), .MAX_PAYLOAD(256)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .rx_i(rx_i), .credit_o(credit_o), .data_i(data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_sop_o(out_sop_o), .out_eop_o(out_eop_o), .pkt_count_o(pkt_count_o),
    .len_err_o(len_err_o), .busy_o(busy_o)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver and scoreboard, both acting on the falling edge.
  initial begin
    logic [W-1:0] exp_e;
    logic [W-1:0] got_e;
    rx_i = 1'b0;
    data_i = '0;
    out_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        rx_i = 1'b0;
        out_ready_i = 1'b0;
        pending = 1'b0;
      end else begin
        case (ready_mode)
          0:       out_ready_i = 1'b0;
          1:       out_ready_i = 1'b1;
          default: out_ready_i = ($urandom_range(0, 3) != 0);
        endcase
        if (out_valid_o && out_ready_i) begin
          recv_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_extra: flit %h delivered, nothing expected", out_data_o);
          end else begin
            exp_e = exp_q.pop_front();
            got_e = {out_sop_o, out_eop_o, out_data_o};
            if (got_e !== exp_e) begin
              errors++;
              $display("FAIL sb_flit: got sop=%b eop=%b data=%h, need sop=%b eop=%b data=%h",
                       got_e[33], got_e[32], got_e[31:0], exp_e[33], exp_e[32], exp_e[31:0]);
            end
            if (exp_e[32]) exp_pkts++;
          end
        end
        if (!pending) begin
          if (tx_q.size() != 0 && (rx_mode == 1 || (rx_mode == 2 && $urandom_range(0, 3) != 0))) begin
            rx_i = 1'b1;
            data_i = tx_q[0][31:0];
            pending = 1'b1;
          end else begin
            rx_i = 1'b0;
            data_i = $urandom();
          end
        end
        if (pending && credit_o) begin
          exp_q.push_back(tx_q.pop_front());
          acc_cnt++;
          pending = 1'b0;
        end
      end
    end
  end

  // Queue one packet with its expected tags; payload words count up from base.
  task automatic add_packet(input logic [31:0] hdr, input logic [31:0] sz, input logic [31:0] base);
    int n;
    n = int'(sz[15:0]);
    if (sz[15:0] > 16'd256) exp_err = 1'b1;
    tx_q.push_back({1'b1, 1'b0, hdr});
    tx_q.push_back({1'b0, (n == 0), sz});
    for (int i = 0; i < n; i++) tx_q.push_back({1'b0, (i == n - 1), base + 32'(i)});
  endtask

  // Wait (bounded) until everything queued has been delivered.
  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((tx_q.size() != 0 || exp_q.size() != 0 || pending) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout: %0d flits still queued, need 0", tx_q.size() + exp_q.size());
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1 rst_ni = 1'b0;
    #11;
    checks++;
    if ({credit_o, out_valid_o, out_sop_o, out_eop_o, len_err_o, busy_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, need 000000",
               {credit_o, out_valid_o, out_sop_o, out_eop_o, len_err_o, busy_o});
    end
    checks++;
    if (pkt_count_o !== 16'd0) begin errors++; $display("FAIL reset_pkt_count: got %0d, need 0", pkt_count_o); end
    checks++;
    if (out_data_o !== 32'd0) begin errors++; $display("FAIL reset_data: got %h, need 0", out_data_o); end
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    checks++;
    if (credit_o !== 1'b0) begin errors++; $display("FAIL credit_first_cycle: got %b, need 0", credit_o); end
    @(negedge clk); #1;
    checks++;
    if (credit_o !== 1'b1) begin errors++; $display("FAIL credit_enabled: got %b, need 1", credit_o); end
  endtask

  task automatic test_basic;
    int a0, r0, n;
    a0 = acc_cnt;
    r0 = recv_cnt;
    ready_mode = 0;
    rx_mode = 1;
    add_packet(32'h0000_0101, 32'd3, 32'hA);
    n = 0;
    while (acc_cnt < a0 + 1 && n < 100) begin @(negedge clk); #1; n++; end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL basic_accept: got %0d accepted, need 1", acc_cnt - a0); end
    checks++;
    if (out_valid_o !== 1'b0) begin errors++; $display("FAIL lat_before: valid got %b, need 0", out_valid_o); end
    @(negedge clk); #1;
    checks++;
    if ({out_valid_o, out_sop_o, out_eop_o, out_data_o} !== {3'b110, 32'h0000_0101}) begin
      errors++;
      $display("FAIL lat_after: got valid=%b sop=%b eop=%b data=%h, need 1 1 0 00000101",
               out_valid_o, out_sop_o, out_eop_o, out_data_o);
    end
    ready_mode = 1;
    wait_idle(200);
    checks++;
    if (pkt_count_o !== 16'd1) begin errors++; $display("FAIL basic_pkt_count: got %0d, need 1", pkt_count_o); end
    checks++;
    if (recv_cnt - r0 !== 5) begin errors++; $display("FAIL basic_flits: got %0d, need 5", recv_cnt - r0); end
    checks++;
    if (len_err_o !== 1'b0) begin errors++; $display("FAIL basic_len_err: got %b, need 0", len_err_o); end
  endtask

  task automatic test_zero_size;
    int r0;
    r0 = recv_cnt;
    add_packet(32'h0000_0202, 32'd0, 32'd0);
    wait_idle(100);
    checks++;
    if (pkt_count_o !== 16'd2) begin errors++; $display("FAIL zero_pkt_count: got %0d, need 2", pkt_count_o); end
    checks++;
    if (recv_cnt - r0 !== 2) begin errors++; $display("FAIL zero_flits: got %0d, need 2", recv_cnt - r0); end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b, need 0", busy_o); end
  endtask

  task automatic test_backpressure;
    int a0, r0;
    a0 = acc_cnt;
    r0 = recv_cnt;
    ready_mode = 0;
    add_packet(32'h0000_0303, 32'd18, 32'h300);
    repeat (30) @(negedge clk);
    #1;
    checks++;
    if (acc_cnt - a0 !== 8) begin errors++; $display("FAIL bp_accepted: got %0d, need 8", acc_cnt - a0); end
    checks++;
    if (credit_o !== 1'b0) begin errors++; $display("FAIL bp_credit_full: got %b, need 0", credit_o); end
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL bp_busy: got %b, need 1", busy_o); end
    ready_mode = 1;
    @(negedge clk); #1;
    checks++;
    if (credit_o !== 1'b0) begin errors++; $display("FAIL bp_credit_before_pop: got %b, need 0", credit_o); end
    @(negedge clk); #1;
    checks++;
    if (credit_o !== 1'b1) begin errors++; $display("FAIL bp_credit_after_pop: got %b, need 1", credit_o); end
    wait_idle(200);
    checks++;
    if (pkt_count_o !== 16'd3) begin errors++; $display("FAIL bp_pkt_count: got %0d, need 3", pkt_count_o); end
    checks++;
    if (recv_cnt - r0 !== 20) begin errors++; $display("FAIL bp_flits: got %0d, need 20", recv_cnt - r0); end
  endtask

  task automatic test_len_err;
    int r0;
    r0 = recv_cnt;
    add_packet(32'h0000_0404, 32'h0000_0200, 32'h4000);
    wait_idle(2000);
    checks++;
    if (len_err_o !== 1'b1) begin errors++; $display("FAIL len_err_set: got %b, need 1", len_err_o); end
    checks++;
    if (pkt_count_o !== 16'd4) begin errors++; $display("FAIL len_pkt_count: got %0d, need 4", pkt_count_o); end
    checks++;
    if (recv_cnt - r0 !== 514) begin errors++; $display("FAIL len_flits: got %0d, need 514", recv_cnt - r0); end
    // Upper size bits are not part of the length: this packet has one payload flit.
    r0 = recv_cnt;
    add_packet(32'h0000_0405, 32'hFFFF_0001, 32'h4100);
    wait_idle(100);
    checks++;
    if (len_err_o !== 1'b1) begin errors++; $display("FAIL len_err_sticky: got %b, need 1", len_err_o); end
    checks++;
    if (pkt_count_o !== 16'd5) begin errors++; $display("FAIL width_pkt_count: got %0d, need 5", pkt_count_o); end
    checks++;
    if (recv_cnt - r0 !== 3) begin errors++; $display("FAIL width_flits: got %0d, need 3", recv_cnt - r0); end
  endtask

  task automatic test_reset_mid;
    int a0, n;
    a0 = acc_cnt;
    ready_mode = 0;
    add_packet(32'h0000_0505, 32'd5, 32'h500);
    n = 0;
    while (acc_cnt < a0 + 4 && n < 100) begin @(negedge clk); #1; n++; end
    rx_mode = 0;
    checks++;
    if (n >= 100) begin errors++; $display("FAIL mid_accept: got %0d accepted, need 4", acc_cnt - a0); end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({busy_o, out_valid_o} !== 2'b11) begin errors++; $display("FAIL mid_busy: got busy=%b valid=%b, need 1 1", busy_o, out_valid_o); end
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({credit_o, out_valid_o, out_sop_o, out_eop_o, len_err_o, busy_o} !== 6'b0) begin
      errors++;
      $display("FAIL mid_reset_flags: got %b, need 000000",
               {credit_o, out_valid_o, out_sop_o, out_eop_o, len_err_o, busy_o});
    end
    checks++;
    if ({pkt_count_o, out_data_o} !== 48'd0) begin
      errors++;
      $display("FAIL mid_reset_data: got count=%0d data=%h, need 0 0", pkt_count_o, out_data_o);
    end
    tx_q.delete();
    exp_q.delete();
    pending = 1'b0;
    exp_pkts = 0;
    exp_err = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    rx_mode = 1;
    ready_mode = 1;
    add_packet(32'h0000_0506, 32'd1, 32'h510);
    wait_idle(100);
    checks++;
    if (pkt_count_o !== 16'd1) begin errors++; $display("FAIL mid_pkt_count: got %0d, need 1", pkt_count_o); end
    checks++;
    if (len_err_o !== 1'b0) begin errors++; $display("FAIL mid_len_err: got %b, need 0", len_err_o); end
  endtask

  task automatic test_len_boundary;
    add_packet(32'h0000_0606, 32'd256, 32'h600);
    wait_idle(1000);
    checks++;
    if (len_err_o !== 1'b0) begin errors++; $display("FAIL len_256: got %b, need 0", len_err_o); end
    add_packet(32'h0000_0607, 32'd257, 32'h700);
    wait_idle(1000);
    checks++;
    if (len_err_o !== 1'b1) begin errors++; $display("FAIL len_257: got %b, need 1", len_err_o); end
    checks++;
    if (pkt_count_o !== 16'd3) begin errors++; $display("FAIL boundary_pkt_count: got %0d, need 3", pkt_count_o); end
  endtask

  task automatic test_random;
    int r0, total;
    rx_mode = 0;
    ready_mode = 0;
    @(negedge clk); #1;
    rst_ni = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    r0 = recv_cnt;
    total = 0;
    for (int p = 0; p < NPKT; p++) begin
      logic [31:0] sz;
      sz = 32'($urandom_range(0, 300));
      total += 2 + int'(sz);
      add_packet($urandom(), sz, $urandom());
    end
    rx_mode = 2;
    ready_mode = 2;
    wait_idle(80000);
    checks++;
    if (pkt_count_o !== 16'(NPKT)) begin errors++; $display("FAIL rand_pkt_count: got %0d, need %0d", pkt_count_o, NPKT); end
    checks++;
    if (recv_cnt - r0 !== total) begin errors++; $display("FAIL rand_flits: got %0d, need %0d", recv_cnt - r0, total); end
    checks++;
    if (len_err_o !== exp_err) begin errors++; $display("FAIL rand_len_err: got %b, need %b", len_err_o, exp_err); end
  endtask

  // Test sequence and report
  initial begin
    test_reset();
    test_basic();
    test_zero_size();
    test_backpressure();
    test_len_err();
    test_reset_mid();
    test_len_boundary();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
